cascade_fifo_stage: RTL and testbench
=====================================

Name: cascade_fifo_stage

Overview:
Single-clock, standard-mode (non-FWFT) synchronous FIFO. It responds to the rd_en/wr_en strobes issued by the inter-stage cascade controller and reports empty/full back to it. One instance sits on each side of every cascade link: the upstream stage is drained via rd_en/empty, and the downstream stage is filled via wr_en/full. Read data appears one cycle after an accepted read, which matches the controller's read-then-write two-state sequence.

Parameters:
DATA_WIDTH, 8, width of din/dout
ADDR_WIDTH, 4, log2 of storage depth
DEPTH, 16, number of entries; must equal 2**ADDR_WIDTH

Ports:
int_clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous active-high reset
wr_en  input  1  write request
din  input  DATA_WIDTH  write data, sampled with wr_en
rd_en  input  1  read request
dout  output  DATA_WIDTH  read data, registered
valid  output  1  dout updated by an accepted read this cycle
full  output  1  registered, count == DEPTH
empty  output  1  registered, count == 0
almost_full  output  1  registered, count >= DEPTH-1
almost_empty  output  1  registered, count <= 1
data_count  output  ADDR_WIDTH+1  registered occupancy 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset: rst is asynchronous, active-high. Clock is int_clk. While rst is high:
  - wr_ptr=0, rd_ptr=0, count=0, dout=0, valid=0
  - empty=1, almost_empty=1, full=0, almost_full=0
  - overflow=0, underflow=0
  - Memory contents are don't-care.
- Accepted write: wr_acc = wr_en & ~full, evaluated against the registered full flag. On wr_acc: mem[wr_ptr]<=din and wr_ptr<=wr_ptr+1, wrapping modulo DEPTH.
- Accepted read: rd_acc = rd_en & ~empty. On rd_acc: dout<=mem[rd_ptr] and rd_ptr<=rd_ptr+1, wrapping modulo DEPTH.
- Read latency: 1 cycle. dout and valid are updated on the same edge that samples rd_acc. valid is high for exactly the following cycle per accepted read. dout holds its value when there is no accepted read.
- count update:
  - count+1 on wr_acc only
  - count-1 on rd_acc only
  - unchanged on both or neither
- Flags are computed from the next count and registered on the same edge, so they reflect occupancy the cycle after the access. No combinational path runs from inputs to flags.
- Simultaneous rd_acc and wr_acc:
  - When empty, rd_acc=0, so only the write proceeds; no fall-through to dout.
  - When full, wr_acc=0, so only the read proceeds. The write is rejected even though a slot frees that cycle, and overflow pulses.
  - Otherwise both proceed, count is unchanged, and pointers never collide.
- overflow <= wr_en & full; underflow <= rd_en & empty. Both are registered one-cycle pulses, asserted the cycle after the offending request. Rejected requests leave state unchanged.
- Reset mid-operation: all state clears immediately. Any in-flight valid is dropped. First write after rst deasserts lands at address 0.
- Pointer wrap: ADDR_WIDTH-bit pointers wrap naturally. Full and empty are decided by count, not by pointer comparison.
- Memory may infer as distributed or block RAM. The read port must be synchronous and registered into dout.

Test Plan:
- Reset then idle: assert rst mid-cycle -> immediately empty=1, full=0, data_count=0, dout=0, valid=0; all hold after release with no strobes.
- Fill to full: write 0x01..0x10 on 16 consecutive cycles -> data_count steps 1..16, almost_full=1 at count 15, full=1 the cycle after 16th write. 17th wr_en (0xAA) -> overflow pulse, count stays 16, 0xAA never read out.
- Drain in order: from full, rd_en for 16 cycles -> dout=0x01..0x10 each one cycle after its rd_en with valid=1, empty=1 after last. Extra rd_en -> underflow pulse, dout stays 0x10, valid=0.
- Simultaneous read/write at count 8 for 20 cycles -> data_count constant 8; output order preserved across pointer wrap, with values written before reads appearing FIFO-ordered.
- Edge cases at the boundaries:
  - Empty with rd_en=wr_en=1 and din=0x55 -> only the write proceeds; count=1; valid=0; next read returns 0x55.
  - Full with both strobes -> read only; count=15; overflow=1.
- Two instances linked by the cascade controller: push 0x10..0x1F into stage 0 -> identical sequence exits stage 1; stage-1 full backpressure (hold downstream rd_en low) stops the controller without loss or duplication; rst mid-transfer -> both stages empty.

Source files
------------

// File: rtl/cascade_fifo_stage.sv
// Single-clock standard-mode (non-FWFT) synchronous FIFO for one side of a cascade link.
// Read data is registered and appears one cycle after an accepted read. All status flags
// are registered from the next-state occupancy, so no input reaches a flag combinationally.
module cascade_fifo_stage #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  int_clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam int unsigned PtrW = ADDR_WIDTH;

  localparam logic [CntW-1:0] CntFull   = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntAlmost = CntW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;

  // Accept decisions and next-state for pointers, occupancy, read data and flags.
  always_comb begin
    // Gated by registered flags: a write while full is refused even if a read frees a slot.
    wr_acc = wr_en & ~full_q;
    rd_acc = rd_en & ~empty_q;

    wr_ptr_d = wr_acc ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PtrOne : rd_ptr_q;

    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CntOne;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CntOne;
    end

    dout_d  = rd_acc ? mem_q[rd_ptr_q] : dout_q;
    valid_d = rd_acc;

    full_d         = (count_d == CntFull);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= CntAlmost);
    almost_empty_d = (count_d <= CntOne);
    overflow_d     = wr_en & full_q;
    underflow_d    = rd_en & empty_q;
  end

  // Storage array; contents are not reset so it can map onto RAM.
  always_ff @(posedge int_clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Control and status state with asynchronous active-high reset.
  always_ff @(posedge int_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      dout_q         <= '0;
      valid_q        <= 1'b0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      dout_q         <= dout_d;
      valid_q        <= valid_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign dout         = dout_q;
  assign valid        = valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign data_count   = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_cascade_fifo_stage.sv
// Directed bench: one standalone FIFO plus a two-stage cascade joined by a
// read-then-write controller.
module tb_cascade_fifo_stage;

  logic int_clk = 1'b0;
  logic rst;
  always #5 int_clk = ~int_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Standalone instance
  logic       wr_en, rd_en;
  logic [7:0] din, dout;
  logic       valid, full, empty, afull, aempty, ovf, udf;
  logic [4:0] cnt;

  cascade_fifo_stage u_dut (
    .int_clk(int_clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .valid(valid), .full(full), .empty(empty), .almost_full(afull),
    .almost_empty(aempty), .data_count(cnt), .overflow(ovf), .underflow(udf)
  );

  // Cascade pair
  logic       s0_wr, s1_rd;
  logic [7:0] s0_din, s0_dout, s1_dout;
  logic       s0_valid, s0_full, s0_empty, s0_af, s0_ae, s0_ovf, s0_udf;
  logic       s1_valid, s1_full, s1_empty, s1_af, s1_ae, s1_ovf, s1_udf;
  logic [4:0] s0_cnt, s1_cnt;
  logic       c_state, c_rd0, c_wr1;

  cascade_fifo_stage u_s0 (
    .int_clk(int_clk), .rst(rst), .wr_en(s0_wr), .din(s0_din), .rd_en(c_rd0),
    .dout(s0_dout), .valid(s0_valid), .full(s0_full), .empty(s0_empty),
    .almost_full(s0_af), .almost_empty(s0_ae), .data_count(s0_cnt),
    .overflow(s0_ovf), .underflow(s0_udf)
  );

  cascade_fifo_stage u_s1 (
    .int_clk(int_clk), .rst(rst), .wr_en(c_wr1), .din(s0_dout), .rd_en(s1_rd),
    .dout(s1_dout), .valid(s1_valid), .full(s1_full), .empty(s1_empty),
    .almost_full(s1_af), .almost_empty(s1_ae), .data_count(s1_cnt),
    .overflow(s1_ovf), .underflow(s1_udf)
  );

  // Controller: read upstream when it has data and downstream has room, then write next cycle.
  always_comb begin
    c_rd0 = (c_state == 1'b0) && !s0_empty && !s1_full;
    c_wr1 = (c_state == 1'b1);
  end

  always @(posedge int_clk or posedge rst) begin
    if (rst) c_state <= 1'b0;
    else if (c_state == 1'b0) c_state <= c_rd0;
    else c_state <= 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge int_clk);
    #1;
  endtask

  byte unsigned got[$];

  initial begin
    rst = 1'b1; wr_en = 0; rd_en = 0; din = 0; s0_wr = 0; s0_din = 0; s1_rd = 0;
    tick(); tick();
    check("rst_empty", empty, 1); check("rst_full", full, 0); check("rst_cnt", cnt, 0);
    check("rst_dout", dout, 0);   check("rst_valid", valid, 0);
    check("rst_aempty", aempty, 1); check("rst_afull", afull, 0);
    rst = 1'b0;
    tick(); tick();
    check("idle_empty", empty, 1); check("idle_cnt", cnt, 0); check("idle_valid", valid, 0);

    // Mid-cycle reset drops an in-flight valid immediately
    wr_en = 1; din = 8'h33; tick(); wr_en = 0;
    rd_en = 1; tick(); rd_en = 0;
    check("pre_rst_valid", valid, 1); check("pre_rst_dout", dout, 8'h33);
    #3 rst = 1'b1; #1;
    check("mid_rst_valid", valid, 0); check("mid_rst_dout", dout, 0);
    check("mid_rst_empty", empty, 1); check("mid_rst_cnt", cnt, 0);
    tick(); rst = 1'b0; tick();

    // Fill to full
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; din = 8'(i + 1); tick();
      check($sformatf("fill_cnt%0d", i), cnt, i + 1);
      check($sformatf("fill_af%0d", i), afull, (i + 1 >= 15) ? 1 : 0);
      check($sformatf("fill_full%0d", i), full, (i == 15) ? 1 : 0);
    end
    din = 8'hAA; tick();
    check("ovf_pulse", ovf, 1); check("ovf_cnt", cnt, 16); check("ovf_full", full, 1);
    wr_en = 0; tick();
    check("ovf_clear", ovf, 0);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      rd_en = 1; tick();
      check($sformatf("drain_valid%0d", i), valid, 1);
      check($sformatf("drain_dout%0d", i), dout, i + 1);
      check($sformatf("drain_cnt%0d", i), cnt, 15 - i);
      check($sformatf("drain_empty%0d", i), empty, (i == 15) ? 1 : 0);
      check($sformatf("drain_ae%0d", i), aempty, (i >= 14) ? 1 : 0);
    end
    tick();
    check("udf_pulse", udf, 1); check("udf_valid", valid, 0); check("udf_dout", dout, 8'h10);
    rd_en = 0; tick();
    check("udf_clear", udf, 0);

    // Simultaneous read/write at count 8 across pointer wrap
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; din = 8'(8'h20 + i); tick();
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1; rd_en = 1; din = 8'(8'h28 + i); tick();
      check($sformatf("rw_cnt%0d", i), cnt, 8);
      check($sformatf("rw_dout%0d", i), dout, 8'h20 + i);
    end
    wr_en = 0;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1; tick();
      check($sformatf("rw_tail%0d", i), dout, 8'h34 + i);
    end
    rd_en = 0; tick();
    check("rw_empty", empty, 1);

    // Empty with both strobes: write only
    wr_en = 1; rd_en = 1; din = 8'h55; tick();
    check("e_both_cnt", cnt, 1); check("e_both_valid", valid, 0); check("e_both_udf", udf, 1);
    wr_en = 0; tick();
    check("e_both_read", dout, 8'h55); check("e_both_rvalid", valid, 1);
    rd_en = 0; tick();

    // Full with both strobes: read only
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; din = 8'(8'h60 + i); tick();
    end
    rd_en = 1; din = 8'hEE; tick();
    check("f_both_cnt", cnt, 15); check("f_both_ovf", ovf, 1);
    check("f_both_dout", dout, 8'h60); check("f_both_full", full, 0);
    wr_en = 0;
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("f_tail%0d", i), dout, 8'h60 + i);
    end
    rd_en = 0; tick();
    check("f_tail_empty", empty, 1);

    // Cascade: 16 items fill stage 1, 8 more back up in stage 0
    for (int i = 0; i < 16; i++) begin
      s0_wr = 1; s0_din = 8'(8'h10 + i); tick();
    end
    s0_wr = 0;
    repeat (40) tick();
    check("cas_s1_cnt", s1_cnt, 16); check("cas_s0_cnt", s0_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      s0_wr = 1; s0_din = 8'(8'h20 + i); tick();
    end
    s0_wr = 0;
    repeat (20) tick();
    check("bp_s0_cnt", s0_cnt, 8); check("bp_s1_full", s1_full, 1);
    check("bp_s1_ovf", s1_ovf, 0);
    for (int k = 0; k < 200 && got.size() < 24; k++) begin
      s1_rd = 1; tick();
      if (s1_valid) got.push_back(s1_dout);
    end
    s1_rd = 0;
    check("cas_count", got.size(), 24);
    for (int i = 0; i < got.size(); i++) begin
      check($sformatf("cas_data%0d", i), got[i], 8'h10 + i);
    end
    tick();
    check("cas_s0_empty", s0_empty, 1);

    // Reset mid-transfer empties both stages
    for (int i = 0; i < 4; i++) begin
      s0_wr = 1; s0_din = 8'(8'h40 + i); tick();
    end
    s0_wr = 0; tick();
    #2 rst = 1'b1; #1;
    check("cas_rst_s0", s0_empty, 1); check("cas_rst_s1", s1_empty, 1);
    check("cas_rst_s1cnt", s1_cnt, 0); check("cas_rst_s1valid", s1_valid, 0);
    tick(); rst = 1'b0; tick();
    check("cas_post_s0", s0_cnt, 0); check("cas_post_s1", s1_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
